hyper_buf_ctrl: RTL and testbench
=================================

# hyper_buf_ctrl

Single-clock sequencer for the one-hot-addressed hyperbus data buffer (`dc_data_buffer_hyper`). It turns a valid/ready push stream and a valid/ready pop stream into the buffer's `write_enable`, one-hot `write_pointer` and one-hot `read_pointer`. It tracks occupancy, full and empty, and supports a synchronous flush. It sits between the uDMA channel logic and the buffer instance; data never passes through this block.

## Interface
Parameters:
- BUFFER_DEPTH, 8, number of buffer entries and width of the one-hot pointers; legal values are 2 or more.
- AF_LEVEL, BUFFER_DEPTH-2, occupancy at or above which `almost_full` asserts; legal range 1..BUFFER_DEPTH.

Ports:
- clk  in  1  the block's only clock.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; empties the buffer on the clock edge.
- in_valid  in  1  producer has a word to push.
- in_ready  out  1  a push is accepted this cycle.
- out_valid  out  1  the buffer's `read_data` holds a valid word.
- out_ready  in  1  consumer takes the word this cycle.
- write_enable  out  1  drives the buffer's `write_enable`.
- write_pointer  out  BUFFER_DEPTH  one-hot write slot; drives the buffer.
- read_pointer  out  BUFFER_DEPTH  one-hot read slot; drives the buffer.
- occupancy  out  $clog2(BUFFER_DEPTH)+1  number of stored words.
- full  out  1  occupancy equals BUFFER_DEPTH.
- empty  out  1  occupancy equals 0.
- almost_full  out  1  watermark flag (see Configuration).

## Operation
- Push: `push = in_valid & in_ready`. `in_ready = ~full & ~clear`. `write_enable = push` (combinational).
- Pop: `pop = out_valid & out_ready`. `out_valid = ~empty & ~clear`.
- Pointer advance:
  - On push, `write_pointer` rotates left by one.
  - On pop, `read_pointer` rotates left by one.
  - Bit BUFFER_DEPTH-1 wraps to bit 0.
  - Each pointer is always exactly one-hot.
- Occupancy update:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged, and both pointers advance.
- Status outputs: `full`, `empty` and `almost_full` are registered, or decoded from registered occupancy only. None of them depends combinationally on `in_valid` or `out_ready`.
- Full: `in_ready` is 0 even if a pop happens in the same cycle. There is no pass-through while full.
- Empty: `out_valid` is 0. A word pushed in cycle N is poppable from cycle N+1. There is no bypass.
- Clear:
  - Has priority over push and pop.
  - During the clear cycle, `write_enable` is 0 and no handshake completes.
  - At the next edge, both pointers return to bit 0 and occupancy returns to 0.
  - Stored data is not erased.
- Illegal states: occupancy never exceeds BUFFER_DEPTH and never underflows.
- Sequencing states: EMPTY (occupancy 0), PARTIAL, FULL (occupancy BUFFER_DEPTH). These are derived from occupancy; there is no separate state register.
  - EMPTY to PARTIAL on push.
  - PARTIAL to FULL on a push-only cycle at occupancy BUFFER_DEPTH-1.
  - FULL to PARTIAL on pop.
  - PARTIAL to EMPTY on a pop-only cycle at occupancy 1.
  - Any state to EMPTY on clear.

## Timing
- Reset values (`rst` high, asynchronous):
  - `write_pointer` = `read_pointer` = 1 (bit 0 set).
  - `occupancy` = 0, `empty` = 1, `full` = 0, `almost_full` = 0.
  - `in_ready` = 1 and `out_valid` = 0 once `clear` is low.
- Reset mid-transfer: any in-flight word is lost. The first edge after `rst` falls behaves as if from reset.
- Combinational paths:
  - `write_enable` follows `in_valid` in the same cycle.
  - There is no combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Latency: push to `out_valid` is 1 cycle. Pop to the freed slot being usable is 1 cycle.
- Throughput: one push and one pop per cycle sustained while 0 < occupancy < BUFFER_DEPTH.
- Buffer read data: the buffer's `read_data` is combinational from `read_pointer` and is valid whenever `out_valid` is 1.
- Top-level wiring: the buffer's `rstn` is driven by `~rst`.

## Configuration
- Macro: `HYPER_BUF_CTRL_ALMOST_FULL_EN`.
- Defined: `almost_full` is a registered flag, equal to (occupancy >= AF_LEVEL) as evaluated on the next-state occupancy. It is cleared by `clear` and by `rst`.
- Undefined: `almost_full` is tied to 0, and the comparator and its flop are not built. The AF_LEVEL parameter is ignored.

## Test plan
- Reset then fill: BUFFER_DEPTH=8, `in_valid`=1 for 8 cycles, `out_ready`=0 -> `write_pointer` walks 0x01,0x02,…,0x80 then back to 0x01. `occupancy` reaches 8, `full`=1, `in_ready`=0 on cycle 9, and `write_enable`=0 on cycle 9.
- Drain with wrap: continue from full, `out_ready`=1 for 8 cycles -> `read_pointer` walks 0x01..0x80 then back to 0x01. Words pop in push order, and `empty`=1 after the 8th pop.
- Simultaneous push/pop at occupancy 3 for 20 cycles -> `occupancy` stays 3 and both pointers advance each cycle. At full, a cycle with `in_valid`=1 and `out_ready`=1 -> only the pop completes, and occupancy goes 8 -> 7.
- Clear mid-stream at occupancy 5 with `in_valid`=1 and `out_ready`=1 -> `write_enable`=0 and no handshake in that cycle. Next cycle: pointers are 0x01, `occupancy`=0, `empty`=1.
- Async reset pulse mid-burst (occupancy 4) -> outputs return to reset values without a clock edge. A push on the first edge after release writes slot 0x01.
- With `HYPER_BUF_CTRL_ALMOST_FULL_EN` and AF_LEVEL=6: `almost_full` rises on the edge where occupancy becomes 6 and falls when it drops to 5. Without the macro, `almost_full` stays 0 throughout.

Source files
------------

// File: rtl/hyper_buf_ctrl.sv
// Push/pop sequencer for the one-hot-addressed hyperbus data buffer: drives write_enable and the
// one-hot pointers, tracks occupancy. Optional macro HYPER_BUF_CTRL_ALMOST_FULL_EN builds the almost_full flag.
module hyper_buf_ctrl #(
  parameter int BUFFER_DEPTH = 8,
  parameter int AF_LEVEL     = BUFFER_DEPTH - 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clear,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            write_enable,
  output logic [BUFFER_DEPTH-1:0]         write_pointer,
  output logic [BUFFER_DEPTH-1:0]         read_pointer,
  output logic [$clog2(BUFFER_DEPTH):0]   occupancy,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic [1:0]                      state_dbg
);

  localparam int OW = $clog2(BUFFER_DEPTH) + 1;
  localparam logic [BUFFER_DEPTH-1:0] PTR_INIT = {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};

  // Sequencing state is decoded from occupancy; there is no state register.
  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  // Handshakes: a transfer completes on a cycle where valid and ready are both high.
  // in_ready never depends on out_ready, out_valid never on in_valid; clear blocks both.
  logic [BUFFER_DEPTH-1:0] wptr_q, wptr_d;
  logic [BUFFER_DEPTH-1:0] rptr_q, rptr_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic                    push, pop;

  assign full      = (occ_q == OW'(BUFFER_DEPTH));
  assign empty     = (occ_q == '0);
  assign in_ready  = ~full & ~clear;
  assign out_valid = ~empty & ~clear;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign write_enable  = push;
  assign write_pointer = wptr_q;
  assign read_pointer  = rptr_q;
  assign occupancy     = occ_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    if (clear) begin
      wptr_d = PTR_INIT;
      rptr_d = PTR_INIT;
      occ_d  = '0;
    end else begin
      if (push) wptr_d = {wptr_q[BUFFER_DEPTH-2:0], wptr_q[BUFFER_DEPTH-1]};
      if (pop)  rptr_d = {rptr_q[BUFFER_DEPTH-2:0], rptr_q[BUFFER_DEPTH-1]};
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= PTR_INIT;
      rptr_q <= PTR_INIT;
      occ_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
    end
  end

  always_comb begin
    state_dbg = ST_PARTIAL;
    if (empty)     state_dbg = ST_EMPTY;
    else if (full) state_dbg = ST_FULL;
  end

`ifdef HYPER_BUF_CTRL_ALMOST_FULL_EN
  logic af_q;

  // Evaluated on next-state occupancy so the flag rises on the same edge occupancy reaches the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        af_q <= 1'b0;
    else if (clear) af_q <= 1'b0;
    else            af_q <= (occ_d >= OW'(AF_LEVEL));
  end

  assign almost_full = af_q;
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_hyper_buf_ctrl.sv
// Directed bench for hyper_buf_ctrl (depth 8, AF_LEVEL 6) with a behavioural buffer and expected-data queue.
module tb_hyper_buf_ctrl;

  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear, in_valid, out_ready;
  logic       in_ready, out_valid, write_enable;
  logic [7:0] write_pointer, read_pointer;
  logic [3:0] occupancy;
  logic       full, empty, almost_full;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [D];
  logic [7:0] push_cnt = 8'd0;
  logic [7:0] exp_q [$];
  logic [7:0] read_data;

  hyper_buf_ctrl #(.BUFFER_DEPTH(D), .AF_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .write_enable(write_enable),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .occupancy(occupancy), .full(full), .empty(empty),
    .almost_full(almost_full), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Behavioural buffer: written at the one-hot write slot, read combinationally at the read slot.
  always @(posedge clk) begin
    if (write_enable) begin
      for (int i = 0; i < D; i++) if (write_pointer[i]) mem[i] <= push_cnt;
      exp_q.push_back(push_cnt);
      push_cnt <= push_cnt + 8'd1;
    end
    if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
  end

  always_comb begin
    read_data = 8'hxx;
    for (int i = 0; i < D; i++) if (read_pointer[i]) read_data = mem[i];
  end

  function automatic logic [7:0] oh(int idx);
    logic [7:0] one;
    one = 8'd1;
    return one << (idx % D);
  endfunction

  function automatic logic af_exp(int occ);
`ifdef HYPER_BUF_CTRL_ALMOST_FULL_EN
    return occ >= 6;
`else
    return 1'b0;
`endif
  endfunction

  // Driver tasks
  task automatic drive(input logic iv, input logic ordy, input logic clr);
    @(negedge clk);
    in_valid = iv; out_ready = ordy; clear = clr;
    #1;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    n_cmp++; if (write_pointer !== 8'h01) begin n_err++; $display("FAIL reset_wptr got %h want 01", write_pointer); end
    n_cmp++; if (read_pointer !== 8'h01) begin n_err++; $display("FAIL reset_rptr got %h want 01", read_pointer); end
    n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_cmp++; if ({empty, full, almost_full} !== 3'b100) begin n_err++; $display("FAIL reset_flags got %b want 100", {empty, full, almost_full}); end
    n_cmp++; if ({in_ready, out_valid} !== 2'b10) begin n_err++; $display("FAIL reset_hs got %b want 10", {in_ready, out_valid}); end
    n_cmp++; if (state_dbg !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_dbg); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_cmp++; if (write_pointer !== oh(i)) begin n_err++; $display("FAIL fill_wptr[%0d] got %h want %h", i, write_pointer, oh(i)); end
      n_cmp++; if (write_enable !== 1'b1) begin n_err++; $display("FAIL fill_we[%0d] got %b want 1", i, write_enable); end
      edge_settle();
      n_cmp++; if (occupancy !== 4'(i + 1)) begin n_err++; $display("FAIL fill_occ[%0d] got %0d want %0d", i, occupancy, i + 1); end
      n_cmp++; if (almost_full !== af_exp(i + 1)) begin n_err++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, af_exp(i + 1)); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL fill_ov[%0d] got %b want 1", i, out_valid); end
    end
    n_cmp++; if ({full, empty, state_dbg} !== 4'b1010) begin n_err++; $display("FAIL full_flags got %b want 1010", {full, empty, state_dbg}); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if ({in_ready, write_enable} !== 2'b00) begin n_err++; $display("FAIL full_block got %b want 00", {in_ready, write_enable}); end
    n_cmp++; if (write_pointer !== 8'h01) begin n_err++; $display("FAIL full_wptr_wrap got %h want 01", write_pointer); end
    edge_settle();
    n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_hold got %0d want 8", occupancy); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      n_cmp++; if (read_pointer !== oh(i)) begin n_err++; $display("FAIL drain_rptr[%0d] got %h want %h", i, read_pointer, oh(i)); end
      n_cmp++; if (read_data !== 8'(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, read_data, 8'(i)); end
      edge_settle();
      n_cmp++; if (occupancy !== 4'(7 - i)) begin n_err++; $display("FAIL drain_occ[%0d] got %0d want %0d", i, occupancy, 7 - i); end
      n_cmp++; if (almost_full !== af_exp(7 - i)) begin n_err++; $display("FAIL drain_af[%0d] got %b want %b", i, almost_full, af_exp(7 - i)); end
    end
    n_cmp++; if ({empty, out_valid, read_pointer} !== {2'b10, 8'h01}) begin n_err++; $display("FAIL drain_end got %b/%b/%h want 1/0/01", empty, out_valid, read_pointer); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    edge_settle();
    n_cmp++; if ({occupancy, write_pointer} !== {4'd3, 8'h08}) begin n_err++; $display("FAIL b2b_prefill got %0d/%h want 3/08", occupancy, write_pointer); end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (exp_q.size() == 0 || read_data !== exp_q[0]) begin
        n_err++; $display("FAIL b2b_data[%0d] got %h want %h", k, read_data, (exp_q.size() > 0) ? exp_q[0] : 8'hxx);
      end
      edge_settle();
      n_cmp++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL b2b_occ[%0d] got %0d want 3", k, occupancy); end
      n_cmp++; if (write_pointer !== oh(4 + k)) begin n_err++; $display("FAIL b2b_wptr[%0d] got %h want %h", k, write_pointer, oh(4 + k)); end
      n_cmp++; if (read_pointer !== oh(1 + k)) begin n_err++; $display("FAIL b2b_rptr[%0d] got %h want %h", k, read_pointer, oh(1 + k)); end
    end
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0);
    edge_settle();
    n_cmp++; if ({full, write_pointer} !== {1'b1, 8'h10}) begin n_err++; $display("FAIL b2b_refill got %b/%h want 1/10", full, write_pointer); end
    drive(1'b1, 1'b1, 1'b0);
    n_cmp++; if ({write_enable, in_ready, out_valid} !== 3'b001) begin n_err++; $display("FAIL full_pushpop_hs got %b want 001", {write_enable, in_ready, out_valid}); end
    edge_settle();
    n_cmp++; if ({occupancy, read_pointer, write_pointer} !== {4'd7, 8'h20, 8'h10}) begin
      n_err++; $display("FAIL full_pushpop got %0d/%h/%h want 7/20/10", occupancy, read_pointer, write_pointer);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 1'b0);
    edge_settle();
    n_cmp++; if (occupancy !== 4'd5) begin n_err++; $display("FAIL clear_pre got %0d want 5", occupancy); end
    drive(1'b1, 1'b1, 1'b1);
    n_cmp++; if ({write_enable, in_ready, out_valid} !== 3'b000) begin n_err++; $display("FAIL clear_hs got %b want 000", {write_enable, in_ready, out_valid}); end
    edge_settle();
    n_cmp++; if ({write_pointer, read_pointer} !== {8'h01, 8'h01}) begin n_err++; $display("FAIL clear_ptr got %h/%h want 01/01", write_pointer, read_pointer); end
    n_cmp++; if ({occupancy, empty, almost_full} !== {4'd0, 2'b10}) begin n_err++; $display("FAIL clear_occ got %0d/%b/%b want 0/1/0", occupancy, empty, almost_full); end
    exp_q.delete();
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
    edge_settle();
    n_cmp++; if ({occupancy, write_pointer} !== {4'd4, 8'h10}) begin n_err++; $display("FAIL ares_pre got %0d/%h want 4/10", occupancy, write_pointer); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({occupancy, write_pointer, read_pointer} !== {4'd0, 8'h01, 8'h01}) begin
      n_err++; $display("FAIL ares_async got %0d/%h/%h want 0/01/01", occupancy, write_pointer, read_pointer);
    end
    n_cmp++; if ({empty, full, out_valid} !== 3'b100) begin n_err++; $display("FAIL ares_flags got %b want 100", {empty, full, out_valid}); end
    exp_q.delete();
    rst = 1'b0;
    #1;
    n_cmp++; if ({write_enable, write_pointer} !== {1'b1, 8'h01}) begin n_err++; $display("FAIL ares_first_push got %b/%h want 1/01", write_enable, write_pointer); end
    edge_settle();
    n_cmp++; if ({occupancy, write_pointer, out_valid} !== {4'd1, 8'h02, 1'b1}) begin
      n_err++; $display("FAIL ares_after got %0d/%h/%b want 1/02/1", occupancy, write_pointer, out_valid);
    end
    drive(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (exp_q.size() != 1 || read_data !== exp_q[0]) begin
      n_err++; $display("FAIL ares_data got %h want slot0 word, queue size %0d", read_data, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
